field_sync_decoder: RTL

FIELD_SYNC_DECODER -- requirements
Module: field_sync_decoder

---
 rtl/field_sync_decoder_if.sv | 22 ++
 rtl/field_sync_decoder.sv | 136 +++++++++++++
 2 files changed

// File: rtl/field_sync_decoder_if.sv
// Sync inputs and decoded field-timing outputs of field_sync_decoder.
// The master side drives enable/syncs; the slave side (the decoder) returns timing.
interface field_sync_decoder_if;
  logic       pixelClockX1_en;
  logic       nHsync;
  logic       nVsync;
  logic [9:0] fieldLine;
  logic       isFieldOdd;
  logic [9:0] linePixel;
  logic       fieldStart;
  logic       locked;

  modport master (
    output pixelClockX1_en, nHsync, nVsync,
    input  fieldLine, isFieldOdd, linePixel, fieldStart, locked
  );

  modport slave (
    input  pixelClockX1_en, nHsync, nVsync,
    output fieldLine, isFieldOdd, linePixel, fieldStart, locked
  );
endinterface

// File: rtl/field_sync_decoder.sv
// DPI field/line/pixel position decoder with field-parity detection and a
// SEARCH/ACQUIRE/LOCKED field-timing lock monitor, advancing on the pixel enable.
module field_sync_decoder #(
  parameter int unsigned H_TOTAL      = 864,
  parameter int unsigned LINES_MIN    = 312,
  parameter int unsigned LINES_MAX    = 313,
  parameter int unsigned LINE_TIMEOUT = 330
) (
  input logic                 pixelClockX6,
  input logic                 nReset,
  field_sync_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } lock_state_e;

  localparam logic [9:0]  CNT_MAX       = '1;
  localparam logic [9:0]  PAR_LO        = 10'(H_TOTAL / 4);
  localparam logic [9:0]  PAR_HI        = 10'((3 * H_TOTAL) / 4);
  localparam logic [10:0] LINES_LO      = 11'(LINES_MIN);
  localparam logic [10:0] LINES_HI      = 11'(LINES_MAX);
  localparam logic [10:0] TIMEOUT_LINES = 11'(LINE_TIMEOUT);

  logic        hs_cur_q, hs_cur_d, hs_prev_q, hs_prev_d;
  logic        vs_cur_q, vs_cur_d, vs_prev_q, vs_prev_d;
  logic [9:0]  line_pixel_q, line_pixel_d;
  logic [9:0]  field_line_q, field_line_d;
  logic        is_odd_q, is_odd_d;
  logic        field_start_q, field_start_d;
  logic        prev_parity_q, prev_parity_d;
  lock_state_e state_q, state_d;

  logic        hs_edge, vs_edge;
  logic        new_odd;
  logic [10:0] line_count;
  logic        field_ok;
  logic        timeout;

  always_ff @(posedge pixelClockX6 or negedge nReset) begin
    if (!nReset) begin
      hs_cur_q      <= 1'b1;
      hs_prev_q     <= 1'b1;
      vs_cur_q      <= 1'b1;
      vs_prev_q     <= 1'b1;
      line_pixel_q  <= '0;
      field_line_q  <= '0;
      is_odd_q      <= 1'b1;
      field_start_q <= 1'b0;
      prev_parity_q <= 1'b0;
      state_q       <= SEARCH;
    end else begin
      hs_cur_q      <= hs_cur_d;
      hs_prev_q     <= hs_prev_d;
      vs_cur_q      <= vs_cur_d;
      vs_prev_q     <= vs_prev_d;
      line_pixel_q  <= line_pixel_d;
      field_line_q  <= field_line_d;
      is_odd_q      <= is_odd_d;
      field_start_q <= field_start_d;
      prev_parity_q <= prev_parity_d;
      state_q       <= state_d;
    end
  end

  // Edges come from two registered samples, giving one enable of latency.
  always_comb begin
    hs_edge    = bus.pixelClockX1_en & hs_prev_q & ~hs_cur_q;
    vs_edge    = bus.pixelClockX1_en & vs_prev_q & ~vs_cur_q;
    new_odd    = ~((line_pixel_q >= PAR_LO) && (line_pixel_q < PAR_HI));
    line_count = {1'b0, field_line_q} + 11'd1;
    field_ok   = (line_count >= LINES_LO) && (line_count <= LINES_HI) &&
                 (new_odd != prev_parity_q);
    timeout    = hs_edge && !vs_edge && (line_count >= TIMEOUT_LINES);
  end

  always_comb begin
    hs_cur_d      = hs_cur_q;
    hs_prev_d     = hs_prev_q;
    vs_cur_d      = vs_cur_q;
    vs_prev_d     = vs_prev_q;
    line_pixel_d  = line_pixel_q;
    field_line_d  = field_line_q;
    is_odd_d      = is_odd_q;
    prev_parity_d = prev_parity_q;
    field_start_d = 1'b0;
    if (bus.pixelClockX1_en) begin
      hs_cur_d  = bus.nHsync;
      hs_prev_d = hs_cur_q;
      vs_cur_d  = bus.nVsync;
      vs_prev_d = vs_cur_q;
      // Vsync takes priority so a coincident hsync cannot leave fieldLine at 1.
      if (vs_edge) begin
        line_pixel_d  = '0;
        field_line_d  = '0;
        field_start_d = 1'b1;
        is_odd_d      = new_odd;
        prev_parity_d = new_odd;
      end else if (hs_edge) begin
        line_pixel_d = '0;
        field_line_d = (field_line_q == CNT_MAX) ? field_line_q : field_line_q + 10'd1;
      end else begin
        line_pixel_d = (line_pixel_q == CNT_MAX) ? line_pixel_q : line_pixel_q + 10'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SEARCH: begin
        if (vs_edge) state_d = ACQUIRE;
      end
      ACQUIRE: begin
        if (vs_edge)      state_d = field_ok ? LOCKED : ACQUIRE;
        else if (timeout) state_d = SEARCH;
      end
      LOCKED: begin
        if (vs_edge)      state_d = field_ok ? LOCKED : SEARCH;
        else if (timeout) state_d = SEARCH;
      end
      default: state_d = SEARCH;
    endcase
  end

  always_comb begin
    bus.fieldLine  = field_line_q;
    bus.linePixel  = line_pixel_q;
    bus.isFieldOdd = is_odd_q;
    bus.fieldStart = field_start_q;
    bus.locked     = (state_q == LOCKED);
  end

endmodule
